// File: rtl/chunk_add_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package chunk_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned calc_nch(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   // Chunk index width: clog2 of the chunk count, never below one bit.
   function automatic int unsigned calc_idx_w(input int unsigned width, input int unsigned chunk);
      int unsigned n;
      n = calc_nch(width, chunk);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CHUNK = 2;
   localparam int unsigned DEF_IDX_W = calc_idx_w(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/chunk_add_sub_ripple_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry into the top bit.
module chunk_ripple_adder #(
   parameter int unsigned CHUNK = 2
) (
   input  logic [CHUNK-1:0] a_chunk,
   input  logic [CHUNK-1:0] b_chunk,
   input  logic             cin,
   output logic [CHUNK-1:0] s_chunk,
   output logic             cout,
   output logic             c_msb_in
);

   logic carry;

   always_comb begin
      carry    = cin;
      c_msb_in = 1'b0;
      s_chunk  = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) c_msb_in = carry;
         s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ carry;
         carry      = (a_chunk[i] & b_chunk[i]) | (carry & (a_chunk[i] ^ b_chunk[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/chunk_add_sub.sv
// Multi-cycle add/subtract, CHUNK bits per clock LSB first, with accumulate mode and flags.
module chunk_add_sub
   import chunk_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   input  logic             sub,
   input  logic             acc_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             done
);

   localparam int unsigned NCH   = calc_nch(WIDTH, CHUNK);
   localparam int unsigned IDX_W = calc_idx_w(WIDTH, CHUNK);
   localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d, work_q, work_d, sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               carry_out_q, carry_out_d, overflow_q, overflow_d;
   logic               zero_q, zero_d, done_q, done_d, ready_q, ready_d;

   logic [31:0]        base;
   logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk;
   logic               cout, c_msb_in;

   // Bit offset of the chunk being processed this cycle.
   assign base    = 32'(idx_q) * CHUNK;
   assign a_chunk = CHUNK'(opa_q >> base);
   assign b_chunk = CHUNK'(opb_q >> base);

   chunk_ripple_adder #(.CHUNK(CHUNK)) u_adder (
      .a_chunk  (a_chunk),
      .b_chunk  (b_chunk),
      .cin      (carry_q),
      .s_chunk  (s_chunk),
      .cout     (cout),
      .c_msb_in (c_msb_in)
   );

   // Next-state, datapath and commit logic.
   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      work_d      = work_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = acc_mode ? sum_q : a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
               work_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            work_d  = (work_q & ~(CMASK << base)) | (WIDTH'(s_chunk) << base);
            carry_d = cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NCH - 1)) begin
               sum_d       = work_d;
               carry_out_d = cout;
               overflow_d  = c_msb_in ^ cout;
               zero_d      = (work_d == '0);
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      done_d  = (state_d == DONE);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         work_q      <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b1;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         work_q      <= work_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   assign ready     = ready_q;
   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign done      = done_q;

endmodule

// File: tb/tb_chunk_add_sub.sv
// Directed bench for chunk_add_sub at 8/2, plus start-held sweeps at 16/4 and 8/8.
module tb_chunk_add_sub;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Main instance, WIDTH=8 CHUNK=2
   logic       start, sub, acc_mode, ready, carry_out, overflow, zero, done;
   logic [7:0] a, b, sum;

   // Sweep instance, WIDTH=16 CHUNK=4
   logic        w_start, w_sub, w_ready, w_carry, w_ovf, w_zero, w_done;
   logic [15:0] w_a, w_b, w_sum;

   // Sweep instance, WIDTH=8 CHUNK=8
   logic       n_start, n_sub, n_ready, n_carry, n_ovf, n_zero, n_done;
   logic [7:0] n_a, n_b, n_sum;

   chunk_add_sub #(.WIDTH(8), .CHUNK(2)) dut (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .sub(sub), .acc_mode(acc_mode),
      .a(a), .b(b), .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero), .done(done)
   );

   chunk_add_sub #(.WIDTH(16), .CHUNK(4)) dut_w (
      .clk(clk), .rst(rst), .start(w_start), .ready(w_ready), .sub(w_sub), .acc_mode(1'b0),
      .a(w_a), .b(w_b), .sum(w_sum), .carry_out(w_carry), .overflow(w_ovf), .zero(w_zero), .done(w_done)
   );

   chunk_add_sub #(.WIDTH(8), .CHUNK(8)) dut_n (
      .clk(clk), .rst(rst), .start(n_start), .ready(n_ready), .sub(n_sub), .acc_mode(1'b0),
      .a(n_a), .b(n_b), .sum(n_sum), .carry_out(n_carry), .overflow(n_ovf), .zero(n_zero), .done(n_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [7:0] es, input logic ec, input logic eo, input logic ez);
      chk({tag, "_sum"}, 32'(sum), 32'(es));
      chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
      chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One operation on the main DUT; optionally pokes a start with other operands mid-RUN.
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic isub, input logic iacc, input bit poke);
      int  lat;
      bit  got;
      @(negedge clk);
      a = ia; b = ib; sub = isub; acc_mode = iacc; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 1) chk({tag, "_ready_run"}, 32'(ready), 32'd0);
         if (poke) begin
            start = (lat == 1);
            if (lat == 1) begin
               a = 8'd50; b = 8'd60; sub = 1'b1;
            end
         end
         if (done) got = 1'b1;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      @(posedge clk);
      #1;
      chk({tag, "_ready_after"}, 32'(ready), 32'd1);
      chk({tag, "_done_low"}, 32'(done), 32'd0);
   endtask

   // Start held high; independent reference model and done-to-done period check.
   task automatic sweep(input bit narrow, input int nops);
      logic [31:0] ea, eb, bb, mask, esum, gsum;
      logic [32:0] r;
      logic        es, ec, eo, ez, gc, go, gz, dn;
      int          w, nch, lat;
      w    = narrow ? 8 : 16;
      nch  = narrow ? 1 : 4;
      mask = (32'd1 << w) - 32'd1;
      @(negedge clk);
      ea = $urandom & mask; eb = $urandom & mask; es = 1'($urandom);
      if (narrow) begin n_a = 8'(ea); n_b = 8'(eb); n_sub = es; n_start = 1'b1; end
      else        begin w_a = 16'(ea); w_b = 16'(eb); w_sub = es; w_start = 1'b1; end
      for (int op = 0; op < nops; op++) begin
         lat = 0;
         dn  = 1'b0;
         while (!dn && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            dn = narrow ? n_done : w_done;
         end
         chk("sweep_done_seen", 32'(dn), 32'd1);
         if (op > 0) chk("sweep_period", 32'(lat), 32'(nch + 2));
         bb   = es ? (~eb & mask) : eb;
         r    = {1'b0, ea} + {1'b0, bb} + 33'(es);
         esum = r[31:0] & mask;
         ec   = r[w];
         eo   = es ? ((ea[w-1] != eb[w-1]) && (esum[w-1] != ea[w-1]))
                   : ((ea[w-1] == eb[w-1]) && (esum[w-1] != ea[w-1]));
         ez   = (esum == 32'd0);
         gsum = narrow ? 32'(n_sum) : 32'(w_sum);
         gc   = narrow ? n_carry : w_carry;
         go   = narrow ? n_ovf : w_ovf;
         gz   = narrow ? n_zero : w_zero;
         chk("sweep_sum", gsum, esum);
         chk("sweep_carry", 32'(gc), 32'(ec));
         chk("sweep_ovf", 32'(go), 32'(eo));
         chk("sweep_zero", 32'(gz), 32'(ez));
         ea = $urandom & mask; eb = $urandom & mask; es = 1'($urandom);
         if (narrow) begin n_a = 8'(ea); n_b = 8'(eb); n_sub = es; end
         else        begin w_a = 16'(ea); w_b = 16'(eb); w_sub = es; end
      end
      n_start = 1'b0;
      w_start = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0; sub = 1'b0; acc_mode = 1'b0; a = '0; b = '0;
      w_start = 1'b0; w_sub = 1'b0; w_a = '0; w_b = '0;
      n_start = 1'b0; n_sub = 1'b0; n_a = '0; n_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk_res("rst", 8'h00, 1'b0, 1'b0, 1'b1);

      run_op("add200_100", 8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
      chk_res("add200_100", 8'd44, 1'b1, 1'b0, 1'b0);

      run_op("sub5_7", 8'd5, 8'd7, 1'b1, 1'b0, 1'b0);
      chk_res("sub5_7", 8'hFE, 1'b0, 1'b0, 1'b0);

      run_op("sub100_100", 8'd100, 8'd100, 1'b1, 1'b0, 1'b0);
      chk_res("sub100_100", 8'h00, 1'b1, 1'b0, 1'b1);

      run_op("add127_1", 8'd127, 8'd1, 1'b0, 1'b0, 1'b0);
      chk_res("add127_1", 8'h80, 1'b0, 1'b1, 1'b0);

      run_op("sub80_1", 8'h80, 8'd1, 1'b1, 1'b0, 1'b0);
      chk_res("sub80_1", 8'h7F, 1'b1, 1'b1, 1'b0);

      apply_reset();
      run_op("acc1", 8'd99, 8'd10, 1'b0, 1'b1, 1'b0);
      chk_res("acc1", 8'd10, 1'b0, 1'b0, 1'b0);
      run_op("acc2", 8'd99, 8'd10, 1'b0, 1'b1, 1'b0);
      chk_res("acc2", 8'd20, 1'b0, 1'b0, 1'b0);
      run_op("acc3", 8'd99, 8'd10, 1'b0, 1'b1, 1'b0);
      chk_res("acc3", 8'd30, 1'b0, 1'b0, 1'b0);
      run_op("accsub", 8'd99, 8'd31, 1'b1, 1'b1, 1'b0);
      chk_res("accsub", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Reset asserted on edge E+2 of a running operation.
      @(negedge clk);
      a = 8'd1; b = 8'd2; sub = 1'b0; acc_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_done_e1", 32'(done), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_ready", 32'(ready), 32'd1);
      chk_res("midrst", 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("midrst_no_done", 32'(done), 32'd0);
      end

      run_op("poke", 8'd3, 8'd4, 1'b0, 1'b0, 1'b1);
      chk_res("poke", 8'd7, 1'b0, 1'b0, 1'b0);
      start = 1'b0;

      sweep(1'b0, 6);
      sweep(1'b1, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chunk_add_sub.md
Name: chunk_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor with accumulate mode; the next generation of the team's 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with a start/ready/done handshake.
- Produces unsigned carry, signed overflow and zero flags.
- Sits between the switch/LED I/O layer and any datapath needing a small-area sequential ALU.

Parameters:
- WIDTH, 8, operand and result width in bits; must be divisible by CHUNK.
- CHUNK, 2, bits processed per clock, 1..WIDTH; NCH = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only while ready=1.
- ready  output  1  high in IDLE only.
- sub  input  1  0 = a+b, 1 = a-b (two's complement); sampled with start.
- acc_mode  input  1  1 = use the current sum output as operand A instead of a; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- sum  output  WIDTH  result; held until the next result completes.
- carry_out  output  1  carry out of the MSB; for sub, 1 = no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.
- done  output  1  one-cycle pulse when sum and flags update.

Behaviour:
- Reset: one clock, synchronous active-high (rst sampled on the rising edge of clk). After it: state IDLE, ready=1, done=0, sum=0, carry_out=0, overflow=0, zero=1.
- Internal state: working result register, carry register and chunk index, all cleared by reset.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> RUN while index < NCH-1; RUN -> DONE after chunk NCH-1.
  - DONE -> IDLE unconditionally.
- Capture, at the start edge E in IDLE:
  - opA = acc_mode ? sum : a.
  - opB = sub ? ~b : b.
  - carry register = sub.
  - index = 0.
- RUN, at edges E+1..E+NCH, chunk k:
  - work[k*CHUNK +: CHUNK] = opA chunk + opB chunk + carry.
  - carry register gets the chunk carry-out.
  - On the last chunk, also record the carry into the MSB for overflow.
- Outputs during RUN: sum and flags keep their previous values; the working register is internal.
- Commit at edge E+NCH (entering DONE):
  - sum, carry_out, overflow and zero update.
  - done=1 for exactly the DONE cycle.
- ready=0 during RUN and DONE; returns to 1 at edge E+NCH+1.
- Back-to-back period with start held high: NCH+2 cycles.
- start while ready=0: ignored, with no queueing; a, b, sub and acc_mode changes during RUN have no effect.
- Widths: result wraps modulo 2^WIDTH; there is no saturation.
- CHUNK=WIDTH: NCH=1, so RUN lasts one cycle.
- Reset mid-operation: aborts immediately to the reset values above; no done pulse is issued.
- rst and start on the same edge: reset wins.

Decomposition:
- Shared package chunk_add_pkg holds:
  - state enum IDLE/RUN/DONE (2-bit encoding 0/1/2);
  - a function computing NCH;
  - an index-width constant, clog2(NCH) with a minimum of 1.
- One natural sub-module, chunk_ripple_adder:
  - combinational CHUNK-bit ripple of full-adder cells;
  - inputs a_chunk, b_chunk, cin;
  - outputs s_chunk, cout, c_msb_in (carry into the top bit, for overflow).
- The sequencing FSM and registers stay in chunk_add_sub.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- Add with carry: a=200, b=100, sub=0, start at edge E -> done=1 only in the cycle after E+4; sum=44, carry_out=1, overflow=0, zero=0; ready=1 again after E+5.
- Subtract with borrow: a=5, b=7, sub=1 -> sum=0xFE, carry_out=0, overflow=0. Then a=100, b=100, sub=1 -> sum=0, zero=1, carry_out=1.
- Signed overflow: a=127, b=1 -> sum=0x80, overflow=1, carry_out=0. Then a=0x80, b=1, sub=1 -> sum=0x7F, overflow=1.
- Accumulate: after reset, three ops with acc_mode=1, b=10 -> sums 10, 20, 30 with done each time. Then acc_mode=1, sub=1, b=31 -> sum=0xFF, carry_out=0.
- Reset mid-run: start a=1, b=2, assert rst at edge E+2 -> no done pulse; sum=0, zero=1, ready=1 after reset. A start ignored during RUN does not alter the result.
- Parameter sweep: (WIDTH=16, CHUNK=4) and (WIDTH=8, CHUNK=8) with start held high -> random operands match a reference model; done period is 6 cycles and 3 cycles respectively.
